// File: rtl/ws2812b_stream_out.sv
// WS2812B / SK6812 serial line driver.
// Pixels arrive on a valid/ready stream and leave MSB-first as pulse-width
// coded bits. Back-to-back pixels chain with no gap; when the stream runs
// dry the line is held low for RESET_CYCLES so the strip latches.
// Optional status outputs (pixel_count, underrun) are enabled by defining
// the macro WS2812B_STATUS_EN.
//
// state | meaning
// IDLE  | line low, waiting for a pixel (pixel_ready=1)
// HIGH  | high phase of the current bit
// LOW   | low phase of the current bit; last cycle of last bit accepts next pixel
// LATCH | latch gap, line low for RESET_CYCLES
module ws2812b_stream_out #(
  parameter int PIXEL_BITS   = 24,
  parameter int T0H_CYCLES   = 4,
  parameter int T1H_CYCLES   = 7,
  parameter int BIT_CYCLES   = 11,
  parameter int RESET_CYCLES = 450
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pixel_valid,
  input  logic [PIXEL_BITS-1:0] pixel_data,
  output logic                  pixel_ready,
  output logic                  ws2812b_data,
  output logic                  busy,
  output logic                  frame_done
`ifdef WS2812B_STATUS_EN
  ,
  output logic [15:0]           pixel_count,
  output logic                  underrun
`endif
);

  localparam int MAX_CYC = (RESET_CYCLES > BIT_CYCLES) ? RESET_CYCLES : BIT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(PIXEL_BITS + 1);

  localparam logic [CNT_W-1:0] T0H_M1  = CNT_W'(T0H_CYCLES - 1);
  localparam logic [CNT_W-1:0] T1H_M1  = CNT_W'(T1H_CYCLES - 1);
  localparam logic [CNT_W-1:0] T0L_M1  = CNT_W'(BIT_CYCLES - T0H_CYCLES - 1);
  localparam logic [CNT_W-1:0] T1L_M1  = CNT_W'(BIT_CYCLES - T1H_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_M1  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PIXEL_BITS - 1);

  generate
    if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES &&
          RESET_CYCLES >= 1 && PIXEL_BITS >= 1 && PIXEL_BITS <= 64)) begin : g_bad_params
      $error("ws2812b_stream_out: illegal timing or width parameters");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [PIXEL_BITS-1:0] shreg, shreg_n, shreg_shl;
  logic [IDX_W-1:0]      idx, idx_n;
  logic                  data_n, busy_n, done_n;
  logic                  xfer;

  assign xfer      = pixel_valid & pixel_ready;
  assign shreg_shl = shreg << 1;

  // State, timing counter, shift register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= LATCH;
      cnt          <= RST_M1;
      shreg        <= '0;
      idx          <= '0;
      ws2812b_data <= 1'b0;
      busy         <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      shreg        <= shreg_n;
      idx          <= idx_n;
      ws2812b_data <= data_n;
      busy         <= busy_n;
      frame_done   <= done_n;
    end
  end

  // Next-state, counter reload and shift decisions.
  always_comb begin
    state_n = state;
    cnt_n   = cnt - CNT_W'(1);
    shreg_n = shreg;
    idx_n   = idx;
    unique case (state)
      IDLE: begin
        cnt_n = cnt;
        if (xfer) begin
          state_n = HIGH;
          shreg_n = pixel_data;
          idx_n   = IDX_TOP;
          cnt_n   = pixel_data[PIXEL_BITS-1] ? T1H_M1 : T0H_M1;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          state_n = LOW;
          cnt_n   = shreg[PIXEL_BITS-1] ? T1L_M1 : T0L_M1;
        end
      end
      LOW: begin
        if (cnt == '0) begin
          if (idx != '0) begin
            state_n = HIGH;
            shreg_n = shreg_shl;
            idx_n   = idx - IDX_W'(1);
            cnt_n   = shreg_shl[PIXEL_BITS-1] ? T1H_M1 : T0H_M1;
          end else if (xfer) begin
            // gapless chaining: the next pixel's first high starts next cycle
            state_n = HIGH;
            shreg_n = pixel_data;
            idx_n   = IDX_TOP;
            cnt_n   = pixel_data[PIXEL_BITS-1] ? T1H_M1 : T0H_M1;
          end else begin
            state_n = LATCH;
            cnt_n   = RST_M1;
          end
        end
      end
      LATCH: begin
        if (cnt == '0) state_n = IDLE;
      end
      default: state_n = LATCH;
    endcase
  end

  // Output decode; ready depends only on registered state, never on pixel_valid.
  always_comb begin
    pixel_ready = (state == IDLE) || (state == LOW && cnt == '0 && idx == '0);
    data_n      = (state_n == HIGH);
    busy_n      = (state_n != IDLE);
    done_n      = (state == LATCH) && (cnt == '0);
  end

`ifdef WS2812B_STATUS_EN
  logic valid_q;

  // Pixel counter (cleared as the latch completes) and sticky underrun flag.
  // Only a latch that follows accepted pixels (pixel_count != 0) can split a
  // frame, so a producer waking up during the power-on gap is not an underrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_count <= '0;
      underrun    <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= pixel_valid;
      if (done_n) pixel_count <= '0;
      else if (xfer && pixel_count != 16'hFFFF) pixel_count <= pixel_count + 16'd1;
      if (state == LATCH && pixel_valid && !valid_q && pixel_count != '0) underrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ws2812b_stream_out.sv
// Self-checking bench for ws2812b_stream_out: a waveform-queue model expands
// each accepted pixel into its expected line levels and tracks the latch gap.
module tb_ws2812b_stream_out;
  localparam int PB   = 24;
  localparam int T0H  = 4;
  localparam int T1H  = 7;
  localparam int BITC = 11;
  localparam int RST  = 450;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pixel_valid = 1'b0;
  logic [PB-1:0] pixel_data = '0;
  logic          pixel_ready, ws2812b_data, busy, frame_done;
`ifdef WS2812B_STATUS_EN
  logic [15:0]   pixel_count;
  logic          underrun;
`endif

  ws2812b_stream_out #(
    .PIXEL_BITS(PB), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H),
    .BIT_CYCLES(BITC), .RESET_CYCLES(RST)
  ) dut (
    .clk(clk), .reset(reset), .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .pixel_ready(pixel_ready), .ws2812b_data(ws2812b_data), .busy(busy),
    .frame_done(frame_done)
`ifdef WS2812B_STATUS_EN
    , .pixel_count(pixel_count), .underrun(underrun)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: queue of expected line levels plus latch countdown
  bit mq[$];
  int latch_left;
  bit m_done;
  int m_count;
  bit m_under;
  bit m_pv;
  int dut_high;
  int dut_done_cnt;

  function automatic void mdl_reset();
    mq.delete();
    latch_left = RST;
    m_done = 0; m_count = 0; m_under = 0; m_pv = 0;
  endfunction

  function automatic void push_pixel(input logic [PB-1:0] d);
    for (int i = PB - 1; i >= 0; i--) begin
      int th;
      th = d[i] ? T1H : T0H;
      for (int k = 0; k < BITC; k++) mq.push_back(k < th);
    end
  endfunction

  function automatic bit m_idle();
    return mq.size() == 0 && latch_left == 0;
  endfunction

  function automatic bit m_ready();
    return m_idle() || mq.size() == 1;
  endfunction

  // one clock cycle: drive inputs, check outputs mid-cycle, advance the model
  task automatic tick(input bit v, input logic [PB-1:0] d);
    bit xfer, nd, in_latch;
    @(negedge clk);
    pixel_valid = v;
    pixel_data  = d;
    #1;
    chk("data", ws2812b_data, (mq.size() > 0) ? mq[0] : 1'b0);
    chk("ready", pixel_ready, m_ready());
    chk("busy", busy, !m_idle());
    chk("done", frame_done, m_done);
`ifdef WS2812B_STATUS_EN
    chk("count", pixel_count, m_count);
    chk("underrun", underrun, m_under);
`endif
    if (ws2812b_data) dut_high++;
    if (frame_done) dut_done_cnt++;
    xfer = v && m_ready();
    in_latch = mq.size() == 0 && latch_left > 0;
    if (in_latch && v && !m_pv && m_count != 0) m_under = 1;
    nd = 0;
    if (mq.size() > 0) begin
      void'(mq.pop_front());
      if (xfer) push_pixel(d);
      else if (mq.size() == 0) latch_left = RST;
    end else if (latch_left > 0) begin
      latch_left--;
      if (latch_left == 0) nd = 1;
    end else if (xfer) begin
      push_pixel(d);
    end
    if (nd) m_count = 0;
    else if (xfer && m_count < 65535) m_count++;
    m_done = nd;
    m_pv = v;
  endtask

  function automatic logic [PB-1:0] rnd_pix();
    return PB'($urandom);
  endfunction

  initial begin
    logic [PB-1:0] src[$];
    int acc;
    int guard;
    bit r;

    mdl_reset();
    pixel_valid = 1'b1;
    pixel_data  = 24'h800000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", ws2812b_data, 0);
    chk("rst_ready", pixel_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_done", frame_done, 0);
    reset = 1'b0;

    // single pixel 0x800000 offered from cycle 0
    dut_high = 0; dut_done_cnt = 0; acc = 0;
    for (int c = 0; c < 1200; c++) begin
      r = m_ready();
      tick(acc == 0, 24'h800000);
      if (acc == 0 && r) acc++;
    end
    chk("p1_high_cycles", dut_high, 7 + 23 * T0H);
    chk("p1_done_pulses", dut_done_cnt, 2);
    chk("p1_idle", busy, 0);

    // three back-to-back pixels
    src = '{24'hFFFFFF, 24'h000000, 24'hA5A5A5};
    dut_high = 0; dut_done_cnt = 0;
    for (int c = 0; c < 1300; c++) begin
      r = m_ready();
      tick(src.size() > 0, (src.size() > 0) ? src[0] : rnd_pix());
      if (src.size() > 0 && r) void'(src.pop_front());
    end
    chk("p2_high_cycles", dut_high, 24 * T1H + 24 * T0H + 12 * T1H + 12 * T0H);
    chk("p2_done_pulses", dut_done_cnt, 1);

    // randomized valid pattern with random data changing every cycle
    for (int c = 0; c < 6000; c++) begin
      tick($urandom_range(0, 3) != 0, rnd_pix());
    end

    // reset asserted while the line is high
    guard = 0;
    while (!(mq.size() > 0 && mq[0] == 1'b1) && guard < 2000) begin
      tick(1'b1, rnd_pix());
      guard++;
    end
    chk("p4_reach_high", guard < 2000, 1);
    @(negedge clk);
    #1;
    chk("p4_pre_high", ws2812b_data, 1);
    reset = 1'b1;
    #1;
    chk("p4_async_data", ws2812b_data, 0);
    chk("p4_async_busy", busy, 1);
    chk("p4_async_ready", pixel_ready, 0);
    mdl_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 700; c++) tick(1'b1, rnd_pix());

    // drop valid exactly on the last-bit ready cycle, then reassert
    guard = 0;
    while (mq.size() != 1 && guard < 2000) begin
      tick(1'b1, rnd_pix());
      guard++;
    end
    chk("p5_reach_last", guard < 2000, 1);
    tick(1'b0, rnd_pix());
    chk("p5_latch_entered", latch_left, RST);
    for (int c = 0; c < 20; c++) tick(1'b1, rnd_pix());
`ifdef WS2812B_STATUS_EN
    chk("p5_underrun", underrun, 1);
`endif
    for (int c = 0; c < 500; c++) tick(1'b1, rnd_pix());

    for (int c = 0; c < 800; c++) tick(1'b0, rnd_pix());
    chk("end_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ws2812b_stream_out.md
Name: ws2812b_stream_out

Overview:
- Parametrised WS2812B/SK6812 serial line driver. Successor to the fixed 24-bit LED output block.
- Accepts pixels over a valid/ready stream and serialises them MSB-first with cycle-programmable high/low timing.
- Chains back-to-back pixels with no gap. When the stream runs dry, it inserts the latch/reset gap.
- Sits between the frame-buffer reader and the LED strip pin. Adds PIXEL_BITS (24 RGB / 32 RGBW), a frame_done pulse and a guaranteed latch gap after reset.

Parameters:
- PIXEL_BITS, 24, bits per pixel (24 GRB, 32 GRBW); range 1..64.
- T0H_CYCLES, 4, high time of a 0 bit in clk cycles (~0.44 us @ 9 MHz).
- T1H_CYCLES, 7, high time of a 1 bit in clk cycles (~0.78 us @ 9 MHz).
- BIT_CYCLES, 11, total bit period in clk cycles (~1.22 us @ 9 MHz).
- RESET_CYCLES, 450, latch gap with line low (50 us @ 9 MHz; set 2520 for 280 us parts).
- Legal only if 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES and RESET_CYCLES >= 1. Elaboration-time check; $error otherwise.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pixel_valid  input  1  pixel_data holds a valid pixel
- pixel_data  input  PIXEL_BITS  pixel, MSB transmitted first
- pixel_ready  output  1  block accepts pixel this cycle (transfer = valid & ready)
- ws2812b_data  output  1  serial line to the strip
- busy  output  1  high in any state other than IDLE
- frame_done  output  1  one-cycle pulse when a latch gap completes

Behaviour:
- All outputs registered except pixel_ready, which is decoded from registered state/counters only; no combinational path from pixel_valid.
- Counter width: $clog2(max(RESET_CYCLES, BIT_CYCLES)+1). Bit index width: $clog2(PIXEL_BITS+1).
- State machine has four states: IDLE, HIGH, LOW, LATCH.
- Reset (async assert):
  - state=LATCH, cnt=RESET_CYCLES-1, ws2812b_data=0, frame_done=0, shift register=0, bit index=0.
  - After release, a full latch gap elapses before the first pixel can start. This also covers reset mid-pixel.
- IDLE:
  - ws2812b_data=0, pixel_ready=1.
  - On transfer: load shift register with pixel_data, bit index=PIXEL_BITS-1, go to HIGH with cnt=(msb ? T1H_CYCLES : T0H_CYCLES)-1, ws2812b_data=1 next cycle.
- HIGH:
  - Line high; cnt decrements.
  - At cnt==0: go to LOW, cnt=BIT_CYCLES-(bit ? T1H : T0H)-1, line low next cycle.
  - Line is high for exactly T1H/T0H cycles per bit.
- LOW:
  - Line low; cnt decrements.
  - At cnt==0 with bit index>0: shift left, decrement index, go to HIGH with timing for the new msb.
  - At cnt==0 with bit index==0 (last bit): pixel_ready=1 this cycle only.
    - With transfer: load next pixel, go to HIGH. Gapless, so the bit period stays exactly BIT_CYCLES.
    - Without transfer: go to LATCH, cnt=RESET_CYCLES-1.
- LATCH:
  - Line low, pixel_ready=0; cnt decrements.
  - At cnt==0: go to IDLE, frame_done=1 for exactly one cycle.
- Data on the wire for a pixel is exactly PIXEL_BITS*BIT_CYCLES cycles.
- pixel_valid may drop at any time outside a transfer cycle. pixel_data is sampled only on the transfer cycle.
- busy=0 only in IDLE.
- pixel_valid held high continuously: pixels stream indefinitely with no latch gap.

Optional Feature:
- Macro WS2812B_STATUS_EN.
- Defined: adds outputs pixel_count [15:0] and underrun (1). pixel_count increments (saturating at 16'hFFFF) per accepted pixel and clears on the frame_done cycle. Sticky underrun sets when pixel_valid rises during LATCH (the frame was split by a late producer), and clears only on reset.
- Undefined: neither port exists; no counters synthesised; all other behaviour identical.

Test Plan:
1. Defaults, reset released, pixel_valid=1, pixel_data=24'h800000 at cycle 0 → ready low for 450 cycles, then transfer. Line high 7 cycles (bit 1), low 4. Then 23 bits of high 4 / low 7. Total 264 cycles, then 450 low, frame_done pulse.
2. Three pixels 24'hFFFFFF, 24'h000000, 24'hA5A5A5 offered back-to-back → 72 consecutive 11-cycle bit periods with no extra low cycle between pixels; one frame_done after the third pixel + 450 cycles.
3. PIXEL_BITS=32, T0H=2, T1H=5, BIT=8, pixel 32'h00000001 → 31 periods high 2/low 6, last period high 5/low 3, ready asserted on the final low cycle.
4. Reset asserted mid-bit while line high → ws2812b_data=0 in the same cycle (async). After release: 450 low cycles, no ready; busy=1 until the gap ends.
5. pixel_valid deasserted for one cycle exactly at the last-bit ready cycle, then reasserted → LATCH entered; with WS2812B_STATUS_EN, underrun=1 and pixel_count=1 clears on frame_done.
6. Parameter set T1H_CYCLES=BIT_CYCLES → elaboration error.
